// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01,
    StGap   = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester-bank to arbiter bundle: request/release in, registered grant out.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: first set request at or above ptr, wrapping 7->0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // Rotate right by ptr so bit 0 of rot is the highest-priority requester.
  assign dbl = {req, req};
  assign rot = N'(dbl >> ptr);

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign win_any = |req;
  assign win_idx = ptr + off;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with held grants, forced release and a break-before-make gap.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             to_q, to_d;

  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             hold_req, at_limit, release_now;

  rr_pick u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign hold_req    = bus.req[idx_q];
  assign at_limit    = (cnt_q == CntW'(MAX_HOLD - 1));
  assign release_now = bus.done || !hold_req || at_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_any) state_d = StGrant;
      StGrant: if (release_now) state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    to_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          gnt_d = N'(1) << win_idx;
          idx_d = win_idx;
          cnt_d = '0;
        end
      end
      StGrant: begin
        if (release_now) begin
          gnt_d = '0;
          idx_d = '0;
          ptr_d = idx_q + IDX_W'(1);
          // Flag only a release forced purely by the hold counter.
          to_d  = at_limit && !bus.done && hold_req;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        gnt_d = '0;
        idx_d = '0;
      end
      default: begin
        gnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic against a model.
module tb_rr_arbiter8;
  import arb_pkg::*;

  localparam int MaxHold = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MaxHold)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks who holds the resource and for how many visible cycles.
  int         m_mode   = 0;  // 0 idle, 1 holding, 2 gap
  int         m_holder = 0;
  int         m_len    = 0;
  int         m_ptr    = 0;
  logic [7:0] exp_gnt  = '0;
  logic [2:0] exp_idx  = '0;
  logic       exp_vld  = 1'b0;
  logic       exp_to   = 1'b0;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode <= 0; m_ptr <= 0; m_len <= 0; m_holder <= 0;
      exp_gnt <= '0; exp_idx <= '0; exp_vld <= 1'b0; exp_to <= 1'b0;
    end else if (m_mode == 0) begin
      exp_to <= 1'b0;
      if (pick(bus.req, m_ptr) >= 0) begin
        m_mode   <= 1;
        m_holder <= pick(bus.req, m_ptr);
        m_len    <= 1;
        exp_gnt  <= 8'(1 << pick(bus.req, m_ptr));
        exp_idx  <= 3'(pick(bus.req, m_ptr));
        exp_vld  <= 1'b1;
      end
    end else if (m_mode == 1) begin
      if (bus.done || !bus.req[m_holder] || m_len == MaxHold) begin
        m_mode  <= 2;
        m_ptr   <= (m_holder + 1) % 8;
        exp_gnt <= '0; exp_idx <= '0; exp_vld <= 1'b0;
        exp_to  <= (m_len == MaxHold) && !bus.done && bus.req[m_holder];
      end else begin
        m_len  <= m_len + 1;
        exp_to <= 1'b0;
      end
    end else begin
      m_mode <= 0;
      exp_to <= 1'b0;
    end
  end

  // Structural invariants on every cycle.
  always @(negedge clk) begin
    int ones;
    int enc;
    ones = 0; enc = 0;
    for (int i = 0; i < 8; i++) if (bus.gnt[i]) begin ones++; enc = i; end
    checks++;
    if (ones > 1) begin errors++; $display("FAIL onehot0 gnt=%b", bus.gnt); end
    checks++;
    if (bus.gnt_valid !== (ones != 0)) begin
      errors++; $display("FAIL valid_or gnt_valid=%b gnt=%b", bus.gnt_valid, bus.gnt);
    end
    checks++;
    if (bus.gnt_idx !== 3'(enc)) begin
      errors++; $display("FAIL idx_enc gnt_idx=%0d want=%0d", bus.gnt_idx, enc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; bus.done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 8'hFF; bus.done = 1'b0;
    tick(); tick();
    checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt got=%h want=00", bus.gnt); end
    checks++; if (bus.gnt_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", bus.gnt_idx); end
    checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.gnt_valid); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
  endtask

  task automatic test_basic();
    reset_dut();
    bus.req = 8'b0010_0100;
    tick();
    checks++; if (bus.gnt !== 8'b0000_0100) begin errors++; $display("FAIL basic_gnt got=%b want=00000100", bus.gnt); end
    checks++; if (bus.gnt_idx !== 3'd2) begin errors++; $display("FAIL basic_idx got=%0d want=2", bus.gnt_idx); end
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL basic_gap got=%b want=0", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL basic_idle got=%b want=0", bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 8'b0010_0000) begin errors++; $display("FAIL basic_gnt2 got=%b want=00100000", bus.gnt); end
    checks++; if (bus.gnt_idx !== 3'd5) begin errors++; $display("FAIL basic_idx2 got=%0d want=5", bus.gnt_idx); end
  endtask

  task automatic test_rotate();
    int n;
    reset_dut();
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      n = 0;
      while (!bus.gnt_valid && n < 10) begin tick(); n++; end
      checks++;
      if (bus.gnt_idx !== 3'(g % 8) || !bus.gnt_valid) begin
        errors++; $display("FAIL rotate_idx g=%0d got=%0d want=%0d", g, bus.gnt_idx, g % 8);
      end
      if (g > 0) begin
        checks++;
        if (n != 2) begin errors++; $display("FAIL rotate_gap g=%0d got=%0d want=2", g, n); end
      end
      bus.done = 1'b1; tick(); bus.done = 1'b0;
    end
  endtask

  task automatic test_timeout();
    int len;
    reset_dut();
    bus.req = 8'b0001_0000;
    tick();
    len = 1;
    while (bus.gnt_valid && len < 40) begin
      tick();
      if (bus.gnt_valid) len++;
    end
    checks++; if (len != MaxHold) begin errors++; $display("FAIL timeout_len got=%0d want=%0d", len, MaxHold); end
    checks++; if (bus.timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse got=%b want=1", bus.timeout); end
    tick();
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL timeout_width got=%b want=0", bus.timeout); end
    tick();
    checks++; if (bus.gnt_idx !== 3'd4 || !bus.gnt_valid) begin
      errors++; $display("FAIL timeout_regrant got=%0d want=4", bus.gnt_idx);
    end
  endtask

  task automatic test_drop_req();
    reset_dut();
    bus.req = 8'b0000_1000;
    tick(); tick(); tick();
    checks++; if (bus.gnt_idx !== 3'd3) begin errors++; $display("FAIL drop_idx got=%0d want=3", bus.gnt_idx); end
    bus.req = 8'b1111_0111;
    tick();
    checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL drop_release got=%b want=0", bus.gnt); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL drop_timeout got=%b want=0", bus.timeout); end
    tick(); tick();
    checks++; if (bus.gnt_idx !== 3'd4) begin errors++; $display("FAIL drop_ptr got=%0d want=4", bus.gnt_idx); end
    for (int i = 0; i < MaxHold - 1; i++) tick();
    checks++; if (bus.gnt_idx !== 3'd4) begin errors++; $display("FAIL coinc_held got=%0d want=4", bus.gnt_idx); end
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL coinc_timeout got=%b want=0", bus.timeout); end
    checks++; if (bus.gnt !== 8'h00) begin errors++; $display("FAIL coinc_release got=%b want=0", bus.gnt); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    bus.req = 8'b0100_0000;
    tick(); tick();
    checks++; if (bus.gnt_idx !== 3'd6) begin errors++; $display("FAIL mid_idx got=%0d want=6", bus.gnt_idx); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0) begin
      errors++; $display("FAIL mid_clear gnt=%b timeout=%b want 0", bus.gnt, bus.timeout);
    end
    bus.req = 8'b0100_0001;
    tick();
    checks++; if (bus.gnt !== 8'b0000_0001) begin errors++; $display("FAIL mid_regrant got=%b want=00000001", bus.gnt); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      bus.req  = 8'($urandom) & 8'($urandom);
      bus.done = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (bus.gnt !== exp_gnt || bus.gnt_idx !== exp_idx || bus.gnt_valid !== exp_vld) begin
        errors++;
        $display("FAIL rand_grant c=%0d gnt=%b idx=%0d vld=%b want gnt=%b idx=%0d vld=%b",
                 c, bus.gnt, bus.gnt_idx, bus.gnt_valid, exp_gnt, exp_idx, exp_vld);
      end
      checks++;
      if (bus.timeout !== exp_to) begin
        errors++; $display("FAIL rand_timeout c=%0d got=%b want=%b", c, bus.timeout, exp_to);
      end
    end
    rst = 1'b0; bus.done = 1'b0;
  endtask

  task automatic test_hold_random();
    // Long held requests so forced releases show up under random traffic.
    reset_dut();
    for (int c = 0; c < 300; c++) begin
      if (c % 40 == 0) bus.req = 8'($urandom);
      bus.done = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (bus.gnt !== exp_gnt || bus.timeout !== exp_to) begin
        errors++;
        $display("FAIL hold_rand c=%0d gnt=%b to=%b want gnt=%b to=%b",
                 c, bus.gnt, bus.timeout, exp_gnt, exp_to);
      end
    end
    bus.done = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.done = 1'b0;
    test_reset();
    test_basic();
    test_rotate();
    test_timeout();
    test_drop_req();
    test_reset_mid();
    test_random();
    test_hold_random();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
